mpmc10_strm_fill_ctrl: RTL

MPMC10_STRM_FILL_CTRL -- requirements
Module: mpmc10_strm_fill_ctrl

---
 rtl/mpmc10_pkg.sv | 17 +
 rtl/mpmc10_strm_fill_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the MPMC10 stream-cache fill path.
// Holds the fill FSM state enum and line geometry (64 beats x 16 bytes).
package mpmc10_pkg;

    localparam int STRM_LINE_BEATS = 64;
    localparam int STRM_BEAT_BYTES = 16;
    localparam int STRM_LINE_BYTES = STRM_LINE_BEATS * STRM_BEAT_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        INV,
        REQ,
        DATA,
        DONE
    } strm_state_e;

endpackage

// File: rtl/mpmc10_strm_fill_ctrl.sv
// Stream read cache line fill controller: invalidates the line, issues one
// burst read, writes 64 returned beats into the cache, aborts on timeout.
// Ports: clk, rst (async, active-low); client fill_req/fill_adr in,
// fill_busy/fill_done/fill_err out; memory mem_req/mem_adr out,
// mem_ack/mem_vld/mem_dat in; cache write port wr/wadr/wdat/inv out.
// Optional macro MPMC10_STRM_PREFETCH_EN: after a demand fill completes
// with fill_req low, the next sequential line is fetched automatically.
module mpmc10_strm_fill_ctrl
    import mpmc10_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fill_req,
    input  logic [31:0]  fill_adr,
    output logic         fill_busy,
    output logic         fill_done,
    output logic         fill_err,
    output logic         mem_req,
    output logic [31:0]  mem_adr,
    input  logic         mem_ack,
    input  logic         mem_vld,
    input  logic [127:0] mem_dat,
    output logic         wr,
    output logic [31:0]  wadr,
    output logic [127:0] wdat,
    output logic         inv
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(STRM_LINE_BEATS);
    localparam int BS = $clog2(STRM_BEAT_BYTES);
    localparam logic [31:0] LINE_MASK = ~32'(STRM_LINE_BYTES - 1);
    localparam logic [31:0] LINE_STEP = 32'(STRM_LINE_BYTES);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
    localparam logic [BW-1:0] BEAT_LAST = BW'(STRM_LINE_BEATS - 1);

    strm_state_e state_q, state_d;
    logic [31:0]   line_q, line_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] to_q, to_d, to_inc;

    logic         busy_d, done_d, err_d;
    logic         mreq_d, wr_d, inv_d;
    logic [31:0]  madr_d, wadr_d;
    logic [127:0] wdat_d;

`ifdef MPMC10_STRM_PREFETCH_EN
    logic pf_q, pf_d;
`endif

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        to_d    = to_q;
        to_inc  = to_q + TW'(1);
        done_d  = 1'b0;
        err_d   = 1'b0;
        mreq_d  = 1'b0;
        madr_d  = '0;
        wr_d    = 1'b0;
        inv_d   = 1'b0;
        wadr_d  = wadr;
        wdat_d  = wdat;
`ifdef MPMC10_STRM_PREFETCH_EN
        pf_d    = pf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    line_d  = fill_adr & LINE_MASK;
                    inv_d   = 1'b1;
                    wadr_d  = line_d;
                    state_d = INV;
`ifdef MPMC10_STRM_PREFETCH_EN
                    pf_d    = 1'b0;
`endif
                end
            end
            INV: begin
                to_d    = '0;
                mreq_d  = 1'b1;
                madr_d  = line_q;
                state_d = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    beat_d  = '0;
                    to_d    = '0;
                    state_d = DATA;
                end else if (to_inc == TO_MAX) begin
                    to_d    = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d    = to_inc;
                    mreq_d  = 1'b1;
                    madr_d  = line_q;
                end
            end
            DATA: begin
                if (mem_vld) begin
                    wr_d   = 1'b1;
                    wdat_d = mem_dat;
                    wadr_d = line_q | (32'(beat_q) << BS);
                    beat_d = beat_q + BW'(1);
                    to_d   = '0;
                    // Beat 63 sets tag+valid in the cache, so the
                    // line is complete once this write lands.
                    if (beat_q == BEAT_LAST) begin
                        state_d = DONE;
`ifdef MPMC10_STRM_PREFETCH_EN
                        done_d  = !pf_q;
`else
                        done_d  = 1'b1;
`endif
                    end
                end else if (to_inc == TO_MAX) begin
                    to_d    = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d    = to_inc;
                end
            end
            DONE: begin
`ifdef MPMC10_STRM_PREFETCH_EN
                // Only a demand fill spawns a prefetch, never a chain.
                if (!pf_q && !fill_req) begin
                    pf_d    = 1'b1;
                    line_d  = line_q + LINE_STEP;
                    inv_d   = 1'b1;
                    wadr_d  = line_d;
                    state_d = INV;
                end else begin
                    pf_d    = 1'b0;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            line_q    <= '0;
            beat_q    <= '0;
            to_q      <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            mem_req   <= 1'b0;
            mem_adr   <= '0;
            wr        <= 1'b0;
            wadr      <= '0;
            wdat      <= '0;
            inv       <= 1'b0;
`ifdef MPMC10_STRM_PREFETCH_EN
            pf_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            to_q      <= to_d;
            fill_busy <= busy_d;
            fill_done <= done_d;
            fill_err  <= err_d;
            mem_req   <= mreq_d;
            mem_adr   <= madr_d;
            wr        <= wr_d;
            wadr      <= wadr_d;
            wdat      <= wdat_d;
            inv       <= inv_d;
`ifdef MPMC10_STRM_PREFETCH_EN
            pf_q      <= pf_d;
`endif
        end
    end

endmodule
